// File: rtl/modular_subtractor.sv
// Two-stage pipelined modular subtractor: c = (a - b) mod q over a fixed table
// of 30-bit NTT primes, with a per-sample modulus tag and a sticky select-error flag.
module modular_subtractor #(
  parameter int unsigned WIDTH      = 30,
  parameter int unsigned NUM_MODULI = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mod_sel,
  input  logic [3:0]       mod_index,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c,
  output logic             mod_err
);

  localparam logic [4:0] NUM_MOD_W = 5'(NUM_MODULI);

  function automatic logic [WIDTH-1:0] q_lookup(input logic [3:0] idx);
    logic [WIDTH-1:0] q;
    q = '0;
    case (idx)
      4'd0:    q = WIDTH'(1063321601);
      4'd1:    q = WIDTH'(1063452673);
      4'd2:    q = WIDTH'(1064697857);
      4'd3:    q = WIDTH'(1065484289);
      4'd4:    q = WIDTH'(1065811969);
      4'd5:    q = WIDTH'(1068236801);
      4'd6:    q = WIDTH'(1068433409);
      4'd7:    q = WIDTH'(1068564481);
      4'd8:    q = WIDTH'(1069219841);
      4'd9:    q = WIDTH'(1070727169);
      4'd10:   q = WIDTH'(1071513601);
      4'd11:   q = WIDTH'(1072496641);
      4'd12:   q = WIDTH'(1073479681);
      default: q = '0;
    endcase
    return q;
  endfunction

  logic [WIDTH-1:0] q_reg;
  logic             index_ok;
  logic             accept;

  logic             v_s1;
  logic [WIDTH:0]   diff_s1;
  logic [WIDTH-1:0] q_s1;

  assign index_ok = ({1'b0, mod_index} < NUM_MOD_W);
  // A select cycle never accepts a sample, even if in_valid is high.
  assign accept   = in_valid && !mod_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= q_lookup(4'd0);
      mod_err <= 1'b0;
    end else if (mod_sel) begin
      if (index_ok) q_reg   <= q_lookup(mod_index);
      else          mod_err <= 1'b1;
    end
  end

  // Stage 1: signed difference plus the modulus tag travelling with the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1    <= 1'b0;
      diff_s1 <= '0;
      q_s1    <= '0;
    end else begin
      v_s1 <= accept;
      if (accept) begin
        diff_s1 <= {1'b0, a} - {1'b0, b};
        q_s1    <= q_reg;
      end
    end
  end

  // Stage 2: single conditional correction; c holds between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      out_valid <= v_s1;
      if (v_s1) begin
        if (diff_s1[WIDTH]) c <= diff_s1[WIDTH-1:0] + q_s1;
        else                c <= diff_s1[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_modular_subtractor.sv
// Self-checking bench for modular_subtractor: directed steps plus a randomized
// phase, checked every cycle against a queue-based arithmetic reference model.
module tb_modular_subtractor;

  localparam int unsigned WIDTH = 30;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             mod_sel = 1'b0;
  logic [3:0]       mod_index = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] c;
  logic             mod_err;

  modular_subtractor #(.WIDTH(WIDTH), .NUM_MODULI(13)) dut (
    .clk(clk), .rst(rst), .mod_sel(mod_sel), .mod_index(mod_index),
    .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .mod_err(mod_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      due;
    longint unsigned  val;
  } exp_t;

  longint unsigned tbl [13] = '{
    64'd1063321601, 64'd1063452673, 64'd1064697857, 64'd1065484289,
    64'd1065811969, 64'd1068236801, 64'd1068433409, 64'd1068564481,
    64'd1069219841, 64'd1070727169, 64'd1071513601, 64'd1072496641,
    64'd1073479681
  };

  exp_t            exp_q [$];
  longint unsigned cur_q;
  longint unsigned last_c;
  logic            err_m;
  int unsigned     cyc = 0;
  int unsigned     errors = 0;
  int unsigned     checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: model the edge from the current inputs, then check all outputs.
  task automatic step();
    exp_t e;
    longint signed d;
    if (mod_sel) begin
      if (mod_index < 4'd13) cur_q = tbl[mod_index];
      else                   err_m = 1'b1;
    end else if (in_valid) begin
      d = longint'(a) - longint'(b);
      if (d < 0) d = d + longint'(cur_q);
      e.due = cyc + 2;
      e.val = longint'(d);
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("out_valid_hi", {31'd0, out_valid}, 32'd1);
      chk("c_result", {2'd0, c}, 32'(exp_q[0].val));
      last_c = exp_q[0].val;
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_lo", {31'd0, out_valid}, 32'd0);
      chk("c_hold", {2'd0, c}, 32'(last_c));
    end
    chk("mod_err", {31'd0, mod_err}, {31'd0, err_m});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mod_sel = 1'b0; in_valid = 1'b0; a = '0; b = '0; mod_index = '0;
    #1;
    exp_q.delete();
    cur_q = tbl[0]; last_c = 0; err_m = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_c", {2'd0, c}, 32'd0);
    chk("rst_mod_err", {31'd0, mod_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample(input longint unsigned av, input longint unsigned bv);
    mod_sel = 1'b0; in_valid = 1'b1; a = WIDTH'(av); b = WIDTH'(bv);
    step();
    in_valid = 1'b0;
  endtask

  task automatic select(input logic [3:0] idx);
    mod_sel = 1'b1; mod_index = idx; in_valid = 1'b0;
    step();
    mod_sel = 1'b0;
  endtask

  // Bounded wait for the next out_valid, then compare c with a literal.
  task automatic expect_next(input string tag, input int unsigned v);
    int unsigned n = 0;
    while (out_valid !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    chk(tag, {2'd0, c}, v);
  endtask

  initial begin
    #2;
    do_reset();
    for (int unsigned i = 0; i < 5; i++) step();

    // Reset with one sample in the output stage and one in stage 1.
    sample(10, 3);
    mod_sel = 1'b0; in_valid = 1'b1; a = 30'd500; b = 30'd900;
    step();
    do_reset();
    for (int unsigned i = 0; i < 4; i++) step();

    for (int unsigned i = 0; i < 13; i++) begin
      select(4'(i));
      sample(0, 1);
      sample(cur_q - 1, cur_q - 1);
      sample(100, 123);
      sample(cur_q - 1, 0);
      step(); step();
    end

    select(4'd12);
    sample(1239384, 9354);
    expect_next("no_wrap_idx12", 1230030);
    select(4'd0);
    sample(1239384, 9354);
    expect_next("no_wrap_idx0", 1230030);
    step(); step();

    select(4'd3);
    for (int unsigned i = 0; i < 4; i++)
      sample($urandom_range(32'(cur_q - 1)), $urandom_range(32'(cur_q - 1)));
    for (int unsigned i = 0; i < 4; i++) step();

    // Sample issued during a select cycle must be dropped.
    select(4'd0);
    sample(0, 1);
    mod_sel = 1'b1; mod_index = 4'd12; in_valid = 1'b1; a = 30'd5; b = 30'd3;
    step();
    mod_sel = 1'b0; in_valid = 1'b0;
    expect_next("tag_first", 1063321600);
    sample(0, 1);
    expect_next("tag_second", 1073479680);
    step(); step(); step();

    select(4'd5);
    select(4'd13);
    select(4'd15);
    sample(0, 1);
    expect_next("bad_index_keeps_q", 1068236800);
    for (int unsigned i = 0; i < 3; i++) step();
    do_reset();
    step();

    for (int unsigned i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(15);
      if (r == 0) begin
        mod_sel = 1'b1; in_valid = 1'(r & 1);
        mod_index = 4'($urandom_range(15));
      end else begin
        mod_sel = 1'b0;
        in_valid = (r > 4);
        a = WIDTH'($urandom_range(32'(cur_q - 1)));
        b = WIDTH'($urandom_range(32'(cur_q - 1)));
      end
      step();
    end
    mod_sel = 1'b0; in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
